// File: rtl/fetch_queue_if.sv
// Bundles the fetch queue's memory, redirect and decode handshakes.
// The fetch queue uses the master view; memory, execute and decode use the slave view.
interface fetch_queue_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [DATA_WIDTH-1:0] imem_req_addr;
    logic                  imem_resp_valid;
    logic [DATA_WIDTH-1:0] imem_resp_data;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [DATA_WIDTH-1:0] inst_out;
    logic [DATA_WIDTH-1:0] inst_pc;

    modport master (
        input  redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
               imem_resp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst_valid, inst_out, inst_pc
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_req_ready, imem_resp_valid,
               imem_resp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst_valid, inst_out, inst_pc
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-limited sequential fetch into a small FIFO,
// with redirect flush and draining of responses to requests that became stale.
module fetch_queue #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    DEPTH      = 4,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic            clk,
    input  logic            rstn,
    fetch_queue_if.master   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } state_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] inst;
    } entry_t;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] fpc_q, fpc_d;
    logic [CNT_W-1:0]      occ_q, occ_d;
    logic [CNT_W-1:0]      out_q, out_d;
    logic [CNT_W-1:0]      drop_q, drop_d;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    entry_t                fifo_mem [DEPTH];

    logic                  redirect;
    logic                  credit_ok;
    logic                  req_valid;
    logic                  req_fire;
    logic                  resp_push;
    logic                  head_valid;
    logic                  pop;
    logic [DATA_WIDTH-1:0] resp_pc;

    assign redirect  = bus.redirect_valid;
    assign credit_ok = ({1'b0, occ_q} + {1'b0, out_q}) < (CNT_W + 1)'(DEPTH);

    // rstn gates the request so it stays low throughout reset yet rises the
    // moment reset is released.
    assign req_valid  = rstn && (state_q == FETCH) && !redirect && credit_ok;
    assign req_fire   = req_valid && bus.imem_req_ready;
    assign resp_push  = (state_q == FETCH) && !redirect && bus.imem_resp_valid;
    assign head_valid = (occ_q != '0);
    assign pop        = head_valid && !redirect && bus.inst_ready;

    // In-flight requests are consecutive words ending just below fpc, so the
    // oldest one (the one answering now) sits out_cnt words back.
    assign resp_pc = fpc_q - (DATA_WIDTH'(out_q) << 2);

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fpc_q;
    assign bus.inst_valid     = head_valid && !redirect;
    assign bus.inst_out       = head_valid ? fifo_mem[rd_ptr_q].inst : '0;
    assign bus.inst_pc        = head_valid ? fifo_mem[rd_ptr_q].pc   : '0;

    // NOTE: every variable gets a default before any branch, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        fpc_d   = fpc_q;
        occ_d   = occ_q;
        out_d   = out_q;
        drop_d  = drop_q;
        if (redirect) begin
            // NOTE: blocking assignments here let out_d reuse drop_d within the same evaluation.
            fpc_d   = bus.redirect_pc & ~DATA_WIDTH'(3);
            occ_d   = '0;
            drop_d  = out_q - CNT_W'(bus.imem_resp_valid);
            out_d   = drop_d;
            state_d = (drop_d != '0) ? DRAIN : FETCH;
        end else begin
            case (state_q)
                FETCH: begin
                    if (req_fire) fpc_d = fpc_q + DATA_WIDTH'(4);
                    out_d = out_q + CNT_W'(req_fire) - CNT_W'(resp_push);
                    occ_d = occ_q + CNT_W'(resp_push) - CNT_W'(pop);
                end
                DRAIN: begin
                    if (bus.imem_resp_valid) begin
                        drop_d = drop_q - CNT_W'(1);
                        out_d  = out_q - CNT_W'(1);
                        if (drop_q == CNT_W'(1)) state_d = FETCH;
                    end
                end
                default: state_d = FETCH;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them update from the same pre-edge values.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= FETCH;
            fpc_q    <= RESET_PC;
            occ_q    <= '0;
            out_q    <= '0;
            drop_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
            occ_q   <= occ_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
            if (redirect) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (resp_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                if (pop)       rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // NOTE: FIFO storage has no reset; occ gates every read, so contents of empty slots are never visible.
    always_ff @(posedge clk) begin
        if (resp_push) begin
            fifo_mem[wr_ptr_q] <= '{pc: resp_pc, inst: bus.imem_resp_data};
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// Randomized bench for fetch_queue: an in-order memory model plus a queue-level
// reference of the instruction stream, compared every cycle, and directed scenarios.
module tb_fetch_queue;
    localparam int          DW       = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        int          due;
        bit          stale;
    } fly_t;

    logic clk  = 1'b0;
    logic rstn = 1'b1;

    fetch_queue_if #(.DATA_WIDTH(DW)) bus ();

    fetch_queue #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .RESET_PC  (RESET_PC)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    ent_t        m_fifo [$];
    fly_t        m_fly  [$];
    logic [31:0] m_fpc = RESET_PC;

    int lat_min = 1, lat_max = 1;
    int ready_pct = 100, resp_pct = 100, iready_pct = 100, redir_pct = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic bit exp_req_valid();
        int stale = 0;
        foreach (m_fly[i]) if (m_fly[i].stale) stale++;
        return rstn && !bus.redirect_valid && (stale == 0) &&
               ((m_fifo.size() + m_fly.size()) < DEPTH);
    endfunction

    function automatic bit exp_inst_valid();
        return rstn && (m_fifo.size() != 0) && !bus.redirect_valid;
    endfunction

    // Advance the reference across one clock edge using the inputs held over it.
    task automatic model_update();
        bit   fire, pop;
        int   lat;
        fly_t h;
        fire = exp_req_valid() && bus.imem_req_ready;
        pop  = exp_inst_valid() && bus.inst_ready;
        lat  = $urandom_range(lat_max, lat_min);
        if (bus.imem_resp_valid) begin
            h = m_fly.pop_front();
            if (!bus.redirect_valid && !h.stale) m_fifo.push_back('{pc: h.addr, inst: h.data});
        end
        if (pop) m_fifo.delete(0);
        if (fire) begin
            m_fly.push_back('{addr: m_fpc, data: $urandom, due: cyc + lat, stale: 1'b0});
            m_fpc = m_fpc + 32'd4;
        end
        if (bus.redirect_valid) begin
            m_fifo.delete();
            foreach (m_fly[i]) m_fly[i].stale = 1'b1;
            m_fpc = {bus.redirect_pc[31:2], 2'b00};
        end
    endtask

    task automatic drive_inputs();
        bus.imem_req_ready = ($urandom_range(99) < ready_pct);
        bus.inst_ready     = ($urandom_range(99) < iready_pct);
        bus.redirect_valid = ($urandom_range(99) < redir_pct);
        bus.redirect_pc    = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(15)) : $urandom;
        if (m_fly.size() != 0 && m_fly[0].due <= cyc && $urandom_range(99) < resp_pct) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = m_fly[0].data;
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = $urandom;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rstn) model_update();
        cyc++;
        drive_inputs();
        #1;
    endtask

    task automatic set_knobs(input int lmin, input int lmax, input int rdy, input int rsp,
                             input int irdy, input int rdr);
        lat_min = lmin; lat_max = lmax; ready_pct = rdy;
        resp_pct = rsp; iready_pct = irdy; redir_pct = rdr;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_pc     = '0;
        bus.imem_req_ready  = 1'b0;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data  = '0;
        bus.inst_ready      = 1'b0;
        m_fifo.delete();
        m_fly.delete();
        m_fpc = RESET_PC;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        cyc  = 0;
        drive_inputs();
        #1;
    endtask

    always @(negedge clk) begin
        if (rstn) begin
            check("req_valid", bus.imem_req_valid, exp_req_valid());
            if (exp_req_valid()) check("req_addr", bus.imem_req_addr, m_fpc);
            check("inst_valid", bus.inst_valid, exp_inst_valid());
            if (exp_inst_valid()) begin
                check("inst_out", bus.inst_out, m_fifo[0].inst);
                check("inst_pc", bus.inst_pc, m_fifo[0].pc);
            end
        end
    end

    initial begin
        int n_req;
        bit found;

        // Asynchronous reset with no clock edge yet.
        #1 rstn = 1'b0;
        #2;
        check("rst_req_valid", bus.imem_req_valid, 0);
        check("rst_inst_valid", bus.inst_valid, 0);
        check("rst_inst_out", bus.inst_out, 0);
        check("rst_inst_pc", bus.inst_pc, 0);

        // 1-cycle memory, decode always ready: back-to-back stream.
        set_knobs(1, 1, 100, 100, 100, 0);
        do_reset();
        check("s_req0_valid", bus.imem_req_valid, 1);
        check("s_req0_addr", bus.imem_req_addr, 32'h0);
        check("s_c0_inst_valid", bus.inst_valid, 0);
        step();
        check("s_req1_addr", bus.imem_req_addr, 32'h4);
        check("s_c1_inst_valid", bus.inst_valid, 0);
        step();
        check("s_req2_addr", bus.imem_req_addr, 32'h8);
        check("s_c2_inst_valid", bus.inst_valid, 1);
        check("s_pc0", bus.inst_pc, 32'h0);
        step();
        check("s_pc1", bus.inst_pc, 32'h4);
        step();
        check("s_pc2", bus.inst_pc, 32'h8);

        // Decode stalled: credits cap requests at DEPTH, one pop frees one.
        set_knobs(1, 1, 100, 100, 0, 0);
        do_reset();
        n_req = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.imem_req_valid && bus.imem_req_ready) n_req++;
            step();
        end
        check("full_req_count", n_req, DEPTH);
        check("full_req_valid", bus.imem_req_valid, 0);
        check("full_inst_valid", bus.inst_valid, 1);
        check("full_head_pc", bus.inst_pc, 32'h0);
        bus.inst_ready = 1'b1;
        step();
        check("full_refill_valid", bus.imem_req_valid, 1);
        check("full_refill_addr", bus.imem_req_addr, 32'h10);
        check("full_new_head_pc", bus.inst_pc, 32'h4);
        step();
        check("full_again", bus.imem_req_valid, 0);

        // Latency 3, two in flight, redirect to an unaligned target.
        set_knobs(3, 3, 100, 100, 100, 0);
        do_reset();
        step();
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h103;
        #1;
        check("dr_redir_req", bus.imem_req_valid, 0);
        step();
        check("dr_c3_req", bus.imem_req_valid, 0);
        check("dr_c3_inst", bus.inst_valid, 0);
        step();
        check("dr_c4_req", bus.imem_req_valid, 0);
        step();
        check("dr_c5_req", bus.imem_req_valid, 1);
        check("dr_c5_addr", bus.imem_req_addr, 32'h100);
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (bus.inst_valid) found = 1;
        end
        check("dr_decode_seen", found, 1);
        if (found) check("dr_decode_pc", bus.inst_pc, 32'h100);

        // Redirect colliding with a response, a pop and a would-be request.
        set_knobs(2, 2, 100, 100, 100, 0);
        do_reset();
        repeat (3) step();
        check("col_pre_inst_valid", bus.inst_valid, 1);
        check("col_pre_req_valid", bus.imem_req_valid, 1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h200;
        #1;
        check("col_req_masked", bus.imem_req_valid, 0);
        check("col_inst_masked", bus.inst_valid, 0);
        step();
        check("col_occ_empty", bus.inst_valid, 0);
        check("col_drain_req", bus.imem_req_valid, 0);
        step();
        check("col_fetch_req", bus.imem_req_valid, 1);
        check("col_fetch_addr", bus.imem_req_addr, 32'h200);

        // Mid-stream reset with three instructions queued.
        set_knobs(1, 1, 100, 100, 0, 0);
        do_reset();
        repeat (4) step();
        check("mr_pre_inst_valid", bus.inst_valid, 1);
        rstn = 1'b0;
        #1;
        check("mr_inst_valid", bus.inst_valid, 0);
        check("mr_req_valid", bus.imem_req_valid, 0);
        check("mr_inst_out", bus.inst_out, 0);
        check("mr_inst_pc", bus.inst_pc, 0);
        do_reset();
        check("mr_first_req", bus.imem_req_valid, 1);
        check("mr_first_addr", bus.imem_req_addr, RESET_PC);

        // Randomized traffic in blocks with shifting pressure.
        for (int blk = 0; blk < 15; blk++) begin
            lat_min = 1 + $urandom_range(1);
            lat_max = lat_min + $urandom_range(3);
            set_knobs(lat_min, lat_max, 30 + $urandom_range(70), 40 + $urandom_range(60),
                      20 + $urandom_range(80), $urandom_range(6));
            repeat (200) step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DATA_WIDTH, default 32, instruction and address width.
REQ-002 Parameter DEPTH, default 4, instruction FIFO entries and maximum in-flight requests (power of two, 2..16).
REQ-003 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-004 clk  input  1  sole clock; all state changes on rising edge.
REQ-005 rstn  input  1  one clock; reset is asynchronous and active-low.
REQ-006 redirect_valid  input  1  flush the queue and restart fetch at redirect_pc (taken branch or jump from the execute stage).
REQ-007 redirect_pc  input  DATA_WIDTH  new fetch address; bits [1:0] ignored and treated as 0.
REQ-008 imem_req_valid  output  1  fetch request to instruction memory.
REQ-009 imem_req_ready  input  1  memory accepts the request this cycle.
REQ-010 imem_req_addr  output  DATA_WIDTH  word-aligned fetch address.
REQ-011 imem_resp_valid  input  1  returned instruction valid; responses arrive in request order, at least 1 cycle after acceptance.
REQ-012 imem_resp_data  input  DATA_WIDTH  returned instruction word.
REQ-013 inst_valid  output  1  FIFO head holds a valid instruction for decode.
REQ-014 inst_ready  input  1  decode consumes the head this cycle.
REQ-015 inst_out  output  DATA_WIDTH  head instruction.
REQ-016 inst_pc  output  DATA_WIDTH  address of the head instruction.

Function
REQ-017 State: fetch PC fpc, FIFO of {pc, inst} pairs, in-flight count out_cnt (0..DEPTH), occupancy occ (0..DEPTH), drop count drop_cnt (0..DEPTH), FSM {FETCH, DRAIN}.
REQ-018 A request transfers only when imem_req_valid && imem_req_ready; on transfer fpc <= fpc + 4 (modulo 2^32) and out_cnt increments.
REQ-019 imem_req_valid = (state == FETCH) && !redirect_valid && (occ + out_cnt < DEPTH), using registered counts only; imem_req_addr = fpc.
REQ-020 In FETCH, a non-stale response (drop_cnt == 0) pushes {pc, imem_resp_data} into the FIFO and decrements out_cnt; the pc pushed is the address of the matching request (tracked by an in-flight pc FIFO or an equivalent counter).
REQ-021 Because of the credit rule, a push never finds the FIFO full; the design shall not drop or overwrite entries.
REQ-022 inst_valid = (occ != 0) && !redirect_valid; a pop occurs on inst_valid && inst_ready.
REQ-023 A push and a pop in the same cycle leave occ unchanged; a push to an empty FIFO makes inst_valid high the next cycle (no bypass; minimum fetch-to-decode latency is the memory latency + 1 cycle).
REQ-024 Redirect has priority over every other event in the cycle: FIFO cleared (occ <= 0), fpc <= {redirect_pc[31:2], 2'b00}, no pop, no request, and any response arriving that cycle is discarded.
REQ-025 On redirect: drop_cnt <= out_cnt - imem_resp_valid, out_cnt <= drop_cnt's value, next state DRAIN if that value is nonzero, else FETCH.
REQ-026 In DRAIN, each imem_resp_valid decrements drop_cnt and out_cnt and is discarded; no requests are issued; when drop_cnt reaches 0 (last stale response), next state is FETCH.
REQ-027 A redirect during DRAIN recomputes drop_cnt per REQ-025 and updates fpc; the state remains DRAIN while stale responses are outstanding.
REQ-028 Pointer wrap-around at DEPTH is modular; occ == DEPTH with out_cnt == 0 is a legal full state with imem_req_valid low.

Reset
REQ-029 While rstn is low: fpc = RESET_PC, occ = out_cnt = drop_cnt = 0, state = FETCH, imem_req_valid = 0, inst_valid = 0, and inst_out and inst_pc = 0.
REQ-030 The first request (addr RESET_PC) is asserted in the first cycle after rstn rises; responses to requests issued before a mid-operation reset are the memory's responsibility and are not tracked.

Verification
REQ-031 Reset, memory with 1-cycle latency, inst_ready=1 -> requests 0x0, 0x4, 0x8 on consecutive cycles; inst_valid first high 2 cycles after the first request; inst_pc sequence 0x0, 0x4, 0x8.
REQ-032 inst_ready=0 held, DEPTH=4 -> exactly 4 requests issued, then imem_req_valid=0 while occ=4; inst_ready=1 for one cycle -> one new request is issued the following cycle.
REQ-033 Memory latency 3 with 2 in flight, redirect_pc=0x103 -> next 2 responses discarded, no request during DRAIN, next request addr 0x100, first decoded inst_pc=0x100.
REQ-034 Redirect in the same cycle as imem_resp_valid, a pop, and a would-be request -> response discarded, occ=0 next cycle, no request accepted, drop_cnt = out_cnt-1.
REQ-035 rstn asserted low mid-stream with occ=3 -> inst_valid and imem_req_valid drop immediately (asynchronously); after release the first request is at RESET_PC.
